// File: rtl/periph_buttons.sv
// Button peripheral for I/O slot 2: synchronises and debounces eight raw buttons,
// latches press/release events (W1C) and raises a maskable interrupt on presses.
module periph_buttons #(
  parameter int PERIPH_DATA_WIDTH = 32,
  parameter int PERIPH_ADDR_WIDTH = 4,
  parameter int DEBOUNCE_CYCLES   = 50000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         read,
  input  logic                         write,
  input  logic [PERIPH_ADDR_WIDTH-1:0] addr,
  inout  wire  [PERIPH_DATA_WIDTH-1:0] data,
  output logic                         ready,
  output logic                         irq,
  input  logic [7:0]                   buttons
);

  localparam logic [15:0] CNT_TC = 16'(DEBOUNCE_CYCLES - 1);

  localparam logic [PERIPH_ADDR_WIDTH-1:0] ADDR_STATE    = PERIPH_ADDR_WIDTH'(0);
  localparam logic [PERIPH_ADDR_WIDTH-1:0] ADDR_PRESSED  = PERIPH_ADDR_WIDTH'(1);
  localparam logic [PERIPH_ADDR_WIDTH-1:0] ADDR_RELEASED = PERIPH_ADDR_WIDTH'(2);
  localparam logic [PERIPH_ADDR_WIDTH-1:0] ADDR_MASK     = PERIPH_ADDR_WIDTH'(3);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } hs_state_t;

  hs_state_t   state;
  hs_state_t   state_next;
  logic        accept;
  logic        wr_en;
  logic        rd_en;

  logic [7:0]  sync_meta;
  logic [7:0]  sync_q;
  logic [7:0]  stable;
  logic [15:0] cnt [8];
  logic [7:0]  commit;
  logic [7:0]  rise;
  logic [7:0]  fall;

  logic [7:0]  pressed;
  logic [7:0]  released;
  logic [7:0]  mask;
  logic [7:0]  rdata_q;
  logic [7:0]  rd_mux;
  logic [7:0]  wdata;
  logic [7:0]  clr_pressed;
  logic [7:0]  clr_released;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= buttons;
      sync_q    <= sync_meta;
    end
  end

  // A bit commits once it has disagreed with the accepted level for DEBOUNCE_CYCLES edges.
  always_comb begin
    commit = '0;
    for (int i = 0; i < 8; i++) begin
      commit[i] = (sync_q[i] != stable[i]) && (cnt[i] == CNT_TC);
    end
    rise = commit & sync_q & ~stable;
    fall = commit & ~sync_q & stable;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable <= '0;
      for (int i = 0; i < 8; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (sync_q[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (commit[i]) begin
          stable[i] <= sync_q[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (read || write) begin
          state_next = ACK;
          accept     = 1'b1;
        end
      end
      ACK: begin
        if (!read && !write) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign ready = (state == ACK);
  // A simultaneous read and write is serviced as a read only.
  assign rd_en = accept && read;
  assign wr_en = accept && write && !read;
  assign wdata = data[7:0];

  always_comb begin
    rd_mux       = '0;
    clr_pressed  = '0;
    clr_released = '0;
    case (addr)
      ADDR_STATE:    rd_mux = stable;
      ADDR_PRESSED:  rd_mux = pressed;
      ADDR_RELEASED: rd_mux = released;
      ADDR_MASK:     rd_mux = mask;
      default:       rd_mux = '0;
    endcase
    if (wr_en && addr == ADDR_PRESSED) begin
      clr_pressed = wdata;
    end
    if (wr_en && addr == ADDR_RELEASED) begin
      clr_released = wdata;
    end
  end

  // New events are OR-ed in after the clear so a same-edge event survives the W1C.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pressed  <= '0;
      released <= '0;
      mask     <= '0;
      irq      <= 1'b0;
      rdata_q  <= '0;
    end else begin
      pressed  <= (pressed & ~clr_pressed) | rise;
      released <= (released & ~clr_released) | fall;
      if (wr_en && addr == ADDR_MASK) begin
        mask <= wdata;
      end
      irq <= |(pressed & mask);
      if (rd_en) begin
        rdata_q <= rd_mux;
      end
    end
  end

  assign data = (read && ready) ? {{(PERIPH_DATA_WIDTH-8){1'b0}}, rdata_q}
                                : {PERIPH_DATA_WIDTH{1'bz}};

endmodule

// File: doc/periph_buttons.md
Name: periph_buttons

Overview:
- Memory-mapped button peripheral attached to the second I/O slot of the I/O bus, alongside the LED peripheral.
- Synchronises and debounces eight raw push-button inputs.
- Latches press and release events in sticky write-1-to-clear registers.
- Exposes levels, events and an interrupt mask over the peripheral read/write/ready handshake that the slot adapter drives.

Parameters:
- PERIPH_DATA_WIDTH, 32: peripheral data bus width; register contents occupy bits [7:0], upper bits read 0.
- PERIPH_ADDR_WIDTH, 4: peripheral register address width.
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required to accept a level change; legal range 2..65535.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- read  input  1  read request from slot; held until ready observed.
- write  input  1  write request from slot; held until ready observed.
- addr  input  PERIPH_ADDR_WIDTH  register address; stable while read or write is high.
- data  inout  PERIPH_DATA_WIDTH  driven only while read && ready, otherwise high-Z; sampled on writes.
- ready  output  1  request acknowledge.
- irq  output  1  registered interrupt request.
- buttons  input  8  raw asynchronous button levels, 1 = pressed.

Behaviour:
- Reset (async): sync stages=0, stable=0, counters=0, PRESSED=0, RELEASED=0, MASK=0, ready=0, irq=0, handshake FSM=IDLE, data=Z.
- Input synchroniser: two flops per bit; sync[i] is buttons[i] delayed two edges.
- Debounce, per bit, 16-bit counter:
  - sync==stable: counter<=0.
  - Differ and counter<DEBOUNCE_CYCLES-1: counter++.
  - Differ and counter==DEBOUNCE_CYCLES-1: stable<=sync, counter<=0.
  - A glitch shorter than DEBOUNCE_CYCLES sync cycles never changes stable.
  - Latency from raw edge to stable update: exactly 2+DEBOUNCE_CYCLES edges.
- Event flags:
  - Same edge stable 0->1: PRESSED[i]<=1.
  - Same edge stable 1->0: RELEASED[i]<=1.
  - Flags are sticky.
- Register map, 8 bits each:
  - 0 STATE (RO): stable levels.
  - 1 PRESSED (R/W1C).
  - 2 RELEASED (R/W1C).
  - 3 MASK (RW): irq enable per bit.
  - Other addresses read 0; writes to them are ignored but still acknowledged.
  - Writes to STATE are ignored.
- Handshake FSM, states IDLE, ACK:
  - IDLE, read||write: go to ACK, ready<=1. A write's side effect commits on this same edge. Read data is registered on this edge and held stable through ACK.
  - ACK, request still high: remain in ACK, ready=1. No repeated side effect.
  - ACK, read&&write both low: go to IDLE, ready<=0.
  - Request-to-ready latency is 1 cycle; minimum transaction is 2 cycles.
  - Back-to-back requests need at least one IDLE cycle between them.
  - read&&write together in IDLE: treated as read; write is ignored.
- W1C collision: if a clear bit and a new event for the same bit occur on the same edge, set wins and the flag stays 1. Bits written 0 are unaffected.
- Read snapshot: the data register captures values before that edge's updates. An event arriving during ACK is not reflected until the next read.
- irq <= |(PRESSED & MASK), registered one edge after the PRESSED or MASK change; RELEASED does not raise irq.
- Reset asserted mid-transaction: everything returns to reset values immediately, ready drops, data goes Z. The slot must re-issue the request.

Test Plan:
Use DEBOUNCE_CYCLES=4 for all cases.
1. Reset release, read addr 0 -> ready rises 1 cycle after read; data=0x00000000; data Z after read drops and ready falls.
2. buttons=0x05 step, held -> STATE reads 0x05 after exactly 6 edges, not before; PRESSED reads 0x05; RELEASED reads 0x00.
3. Pulse buttons[3] high for 3 clocks, then low -> STATE, PRESSED and RELEASED all stay 0x00.
4. With PRESSED=0x05, write 0x01 to addr 1 -> PRESSED reads 0x04. Then write 0x04 with MASK=0x04 -> irq falls one edge after the clear commits.
5. Write MASK=0x02, press buttons[1] -> irq=1 one edge after PRESSED[1] sets. Release buttons[1] -> RELEASED=0x02 and irq stays 1 until PRESSED is cleared.
6. Issue a W1C to PRESSED bit 0 on the same edge that stable[0] rises -> PRESSED[0] stays 1.
   Separately, assert reset while in ACK -> ready=0 and data=Z immediately.
